// File: rtl/io_pkg.sv
// Shared types for the pad output driver.
//   io_mode_e  : command mode encoding carried on cmd_mode
//   io_state_e : driver FSM states
//   DEFAULT_CNT_W : default width of the pulse-width / half-period counter
package io_pkg;

    localparam int unsigned DEFAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        MODE_LEVEL = 2'd0,
        MODE_PULSE = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_HIZ   = 2'd3
    } io_mode_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPulse = 2'd1,
        StBlink = 2'd2
    } io_state_e;

endpackage

// File: rtl/io_output_driver_if.sv
// Command channel between the MCU-facing register logic and the pad driver.
//   cmd_valid : command strobe (master)
//   cmd_ready : driver can accept a command this cycle (slave)
//   cmd_mode  : LEVEL / PULSE / BLINK / HIZ
//   cmd_level : drive value, pulse polarity or blink start value
//   cmd_count : pulse width or blink half-period in cycles, 0 treated as 1
interface io_output_driver_if
    import io_pkg::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W
);
    logic             cmd_valid;
    logic             cmd_ready;
    io_mode_e         cmd_mode;
    logic             cmd_level;
    logic [CNT_W-1:0] cmd_count;

    modport master (
        output cmd_valid,
        output cmd_mode,
        output cmd_level,
        output cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_mode,
        input  cmd_level,
        input  cmd_count,
        output cmd_ready
    );

endinterface

// File: rtl/io_readback_check.sv
// Pad readback checker: synchronizes the raw pad, waits for the pad to settle after
// every drive change, and raises a sticky fault when the pad disagrees with the
// driven value while the driver is actively driving.
//   clk, rst_n    : clock, synchronous active-low reset
//   pin_out       : currently driven pad value (registered)
//   pin_hiz       : currently driven tristate (registered), 1 = no compare
//   drive_change  : pin_out or pin_hiz changes on this edge
//   pin_in        : raw asynchronous pad readback
//   fault_clr     : clears the sticky fault (a same-cycle set wins)
//   fault         : sticky mismatch flag
module io_readback_check
    import io_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned SYNC_STAGES = 3   // minimum 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_out,
    input  logic pin_hiz,
    input  logic drive_change,
    input  logic pin_in,
    input  logic fault_clr,
    output logic fault
);

    localparam int unsigned SettleLoad = SETTLE_CYC + SYNC_STAGES;
    localparam int unsigned SettleW    = $clog2(SettleLoad + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SettleW-1:0]     settle_q, settle_d;
    logic                   fault_q, fault_d;
    logic                   rb;
    logic                   mismatch;

    assign rb = sync_q[SYNC_STAGES-1];

    // The settle window covers both the pad's own settling and the synchronizer
    // latency, so a compare never sees a stale readback of the old drive value.
    always_comb begin
        settle_d = settle_q;
        if (drive_change) begin
            settle_d = SettleW'(SettleLoad);
        end else if (settle_q != '0) begin
            settle_d = settle_q - SettleW'(1);
        end
    end

    assign mismatch = (settle_q == '0) && !pin_hiz && (rb != pin_out);
    assign fault_d  = mismatch | (fault_q & ~fault_clr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q   <= '0;
            settle_q <= SettleW'(SettleLoad);
            fault_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pin_in};
            settle_q <= settle_d;
            fault_q  <= fault_d;
        end
    end

    assign fault = fault_q;

endmodule

// File: rtl/io_output_driver.sv
// Command-driven pad driver. Drives one pad from registered outputs as a static
// level, a single timed pulse, a continuous blink, or high-Z. All pad outputs
// update on the edge that accepts a command; there is no path from cmd_* to pin_*.
//   clk, rst_n  : clock, synchronous active-low reset
//   cmd         : command channel (io_output_driver_if.slave)
//   pin_out     : registered pad data
//   pin_hiz     : registered pad tristate, 1 = high-Z
//   pin_in      : raw pad readback (used only with IO_OUT_READBACK_EN)
//   fault_clr   : clears sticky fault (used only with IO_OUT_READBACK_EN)
//   busy        : registered, 1 while pulsing or blinking
//   fault       : sticky readback mismatch, tied 0 without IO_OUT_READBACK_EN
// Build option: define IO_OUT_READBACK_EN to include the readback checker.
module io_output_driver
    import io_pkg::*;
#(
    parameter int unsigned CNT_W       = DEFAULT_CNT_W,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    io_output_driver_if.slave  cmd,
    output logic               pin_out,
    output logic               pin_hiz,
    input  logic               pin_in,
    input  logic               fault_clr,
    output logic               busy,
    output logic               fault
);

    io_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             out_q, out_d;
    logic             hiz_q, hiz_d;
    logic             rest_out_q, rest_out_d;
    logic             rest_hiz_q, rest_hiz_d;
    logic             busy_q;
    logic             accept;
    logic [CNT_W-1:0] load_val;

    // Pulses are not interruptible; a blink accepts commands that pre-empt it.
    assign cmd.cmd_ready = (state_q != StPulse);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    // Counter counts down to 0 inclusive, so load max(count,1)-1.
    assign load_val = (cmd.cmd_count == '0) ? '0 : cmd.cmd_count - CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        half_d     = half_q;
        out_d      = out_q;
        hiz_d      = hiz_q;
        rest_out_d = rest_out_q;
        rest_hiz_d = rest_hiz_q;

        unique case (state_q)
            StIdle, StBlink: begin
                if (accept) begin
                    state_d = StIdle;
                    unique case (cmd.cmd_mode)
                        MODE_LEVEL: begin
                            out_d = cmd.cmd_level;
                            hiz_d = 1'b0;
                        end
                        MODE_HIZ: begin
                            hiz_d = 1'b1;
                        end
                        MODE_PULSE: begin
                            rest_out_d = out_q;
                            rest_hiz_d = hiz_q;
                            out_d      = cmd.cmd_level;
                            hiz_d      = 1'b0;
                            cnt_d      = load_val;
                            state_d    = StPulse;
                        end
                        MODE_BLINK: begin
                            out_d   = cmd.cmd_level;
                            hiz_d   = 1'b0;
                            cnt_d   = load_val;
                            half_d  = load_val;
                            state_d = StBlink;
                        end
                    endcase
                end else if (state_q == StBlink) begin
                    if (cnt_q == '0) begin
                        out_d = ~out_q;
                        cnt_d = half_q;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            StPulse: begin
                if (cnt_q == '0) begin
                    out_d   = rest_out_q;
                    hiz_d   = rest_hiz_q;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            half_q     <= '0;
            out_q      <= 1'b0;
            hiz_q      <= 1'b1;
            rest_out_q <= 1'b0;
            rest_hiz_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            out_q      <= out_d;
            hiz_q      <= hiz_d;
            rest_out_q <= rest_out_d;
            rest_hiz_q <= rest_hiz_d;
            busy_q     <= (state_d != StIdle);
        end
    end

    assign pin_out = out_q;
    assign pin_hiz = hiz_q;
    assign busy    = busy_q;

`ifdef IO_OUT_READBACK_EN
    logic drive_change;
    assign drive_change = (out_d != out_q) || (hiz_d != hiz_q);

    io_readback_check #(
        .SETTLE_CYC  (SETTLE_CYC),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_readback_check (
        .clk          (clk),
        .rst_n        (rst_n),
        .pin_out      (out_q),
        .pin_hiz      (hiz_q),
        .drive_change (drive_change),
        .pin_in       (pin_in),
        .fault_clr    (fault_clr),
        .fault        (fault)
    );
`else
    logic unused_readback;
    assign unused_readback = pin_in ^ fault_clr;
    assign fault           = 1'b0;
`endif

endmodule

// File: tb/tb_io_output_driver.sv
// Scoreboard bench for io_output_driver. Each scenario pushes the per-cycle
// expected {pin_out, pin_hiz, busy, cmd_ready, fault} and the run task pops one
// entry per clock and compares it with the sampled outputs.
module tb_io_output_driver;
    import io_pkg::*;

    localparam int unsigned CNT_W       = 16;
    localparam int unsigned SETTLE_CYC  = 4;
    localparam int unsigned SYNC_STAGES = 3;
`ifdef IO_OUT_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic fault_clr = 1'b0;
    logic stuck_en  = 1'b0;
    logic stuck_val = 1'b0;
    logic pin_out, pin_hiz, pin_in, busy, fault;

    io_output_driver_if #(.CNT_W(CNT_W)) cmd_if ();

    io_output_driver #(
        .CNT_W       (CNT_W),
        .SETTLE_CYC  (SETTLE_CYC),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd_if),
        .pin_out   (pin_out),
        .pin_hiz   (pin_hiz),
        .pin_in    (pin_in),
        .fault_clr (fault_clr),
        .busy      (busy),
        .fault     (fault)
    );

    // Healthy pad loops the driven value back (reads 0 when floating).
    assign pin_in = stuck_en ? stuck_val : (pin_hiz ? 1'b0 : pin_out);

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [4:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (out,hiz,busy,rdy,fault) at %0t",
                     tag, got[4:0], exp[4:0], $time);
        end
    endtask

    task automatic expect_n(input string tag, input bit o, input bit h, input bit b,
                            input bit r, input bit f, input int n);
        exp_t e;
        e.tag = tag;
        e.val = {o, h, b, r, f};
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cmd_if.cmd_valid = 1'b0;
            fault_clr        = 1'b0;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check_val(e.tag, {27'd0, pin_out, pin_hiz, busy, cmd_if.cmd_ready, fault},
                          {27'd0, e.val});
            end
        end
    endtask

    task automatic send(input io_mode_e mode, input logic level, input logic [CNT_W-1:0] count);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_mode  = mode;
        cmd_if.cmd_level = level;
        cmd_if.cmd_count = count;
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_mode  = MODE_LEVEL;
        cmd_if.cmd_level = 1'b0;
        cmd_if.cmd_count = '0;

        // Reset held for two cycles.
        expect_n("reset", 0, 1, 0, 1, 0, 2);
        run(2);
        rst_n = 1'b1;
        expect_n("idle", 0, 1, 0, 1, 0, 1);
        run(1);

        // LEVEL 1 then HIZ keeps pin_out.
        send(MODE_LEVEL, 1'b1, '0);
        expect_n("level1", 1, 0, 0, 1, 0, 10);
        run(10);
        send(MODE_HIZ, 1'b0, '0);
        expect_n("hiz_keep", 1, 1, 0, 1, 0, 3);
        run(3);

        // PULSE 5 from LEVEL 0.
        send(MODE_LEVEL, 1'b0, '0);
        expect_n("level0", 0, 0, 0, 1, 0, 10);
        run(10);
        send(MODE_PULSE, 1'b1, 16'd5);
        expect_n("pulse5", 1, 0, 1, 0, 0, 5);
        expect_n("pulse5_end", 0, 0, 0, 1, 0, 10);
        run(15);

        // Count 0 behaves as a 1-cycle pulse.
        send(MODE_PULSE, 1'b1, 16'd0);
        expect_n("pulse0", 1, 0, 1, 0, 0, 1);
        expect_n("pulse0_end", 0, 0, 0, 1, 0, 3);
        run(4);

        // Pulse from HIZ returns to high-Z; command during pulse is not accepted.
        send(MODE_HIZ, 1'b0, '0);
        expect_n("hiz", 0, 1, 0, 1, 0, 2);
        run(2);
        send(MODE_PULSE, 1'b1, 16'd2);
        expect_n("pulse_hiz", 1, 0, 1, 0, 0, 1);
        run(1);
        send(MODE_LEVEL, 1'b1, '0);   // cmd_ready=0 here: must be ignored
        cmd_if.cmd_valid = 1'b1;
        expect_n("pulse_hiz", 1, 0, 1, 0, 0, 1);
        expect_n("pulse_hiz_end", 0, 1, 0, 1, 0, 3);
        run(4);

        // BLINK half-period 3 starting low, pre-empted by LEVEL 1.
        send(MODE_BLINK, 1'b0, 16'd3);
        expect_n("blink_lo", 0, 0, 1, 1, 0, 3);
        expect_n("blink_hi", 1, 0, 1, 1, 0, 3);
        expect_n("blink_lo2", 0, 0, 1, 1, 0, 1);
        run(7);
        send(MODE_LEVEL, 1'b1, '0);
        expect_n("blink_preempt", 1, 0, 0, 1, 0, 6);
        run(6);

        // Reset in the middle of a blink.
        send(MODE_BLINK, 1'b1, 16'd4);
        expect_n("blink2", 1, 0, 1, 1, 0, 2);
        run(2);
        rst_n = 1'b0;
        expect_n("rst_mid_blink", 0, 1, 0, 1, 0, 1);
        run(1);
        rst_n = 1'b1;
        expect_n("idle2", 0, 1, 0, 1, 0, 2);
        run(2);

        // Pad stuck low while driving 1.
        stuck_en  = 1'b1;
        stuck_val = 1'b0;
        send(MODE_LEVEL, 1'b1, '0);
        expect_n("rb_settle", 1, 0, 0, 1, 0, SETTLE_CYC + SYNC_STAGES + 1);
        expect_n("rb_fault", 1, 0, 0, 1, RB, 2);
        run(SETTLE_CYC + SYNC_STAGES + 3);
        fault_clr = 1'b1;
        expect_n("rb_clr_set_wins", 1, 0, 0, 1, RB, 1);
        run(1);
        send(MODE_HIZ, 1'b0, '0);
        expect_n("rb_hiz", 1, 1, 0, 1, RB, 1);
        run(1);
        fault_clr = 1'b1;
        expect_n("rb_hiz_clear", 1, 1, 0, 1, 0, 10);
        run(10);

        check_val("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
